mem_arbiter: RTL and testbench

Shares the single 64×8 memory port between up to NREQ bus masters: the CPU control unit, a program loader, a debug port. Each master raises a request with address, direction and write data. The arbiter picks one by round-robin, drives one memory cycle and returns an acknowledge with read data. It owns the memory's address, READ and write strobes; no master drives the memory directly.

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/rr_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Optional bus-lock feature is enabled by defining MEM_ARB_LOCK_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_AW   = 6;
  localparam int DEF_DW   = 8;
  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = 2;

  // Round-robin search: first requester with req set, starting at last+1 mod nreq.
  function automatic logic [MAX_NREQ-1:0] rr_search(
    input logic [MAX_NREQ-1:0] req,
    input logic [IDX_W-1:0]    last,
    input int                  nreq
  );
    logic [MAX_NREQ-1:0] grant;
    logic [IDX_W-1:0]    idx;
    grant = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      idx = IDX_W'((int'(last) + k) % nreq);
      if (k <= nreq && grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner among req, searching
// from last_winner+1, plus a valid bit when any request is present.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_NREQ-1:0] pick;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign pick   = rr_search(req_ext, last_winner, NREQ);
  assign winner = pick[NREQ-1:0];
  assign valid  = |pick;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter owning a single memory port shared by NREQ masters.
// Define MEM_ARB_LOCK_EN to add the lock input and consecutive-grant counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW
`ifdef MEM_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  state_t              state;
  logic [IDX_W-1:0]    last_winner;
  logic [NREQ-1:0]     win_oh;
  logic                we_l;

  logic [NREQ-1:0]     pick_oh;
  logic                pick_valid;
  logic [NREQ-1:0]     next_oh;
  logic [MAX_NREQ-1:0] next_oh_ext;
  logic                next_valid;
  logic                relock;

  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (pick_oh),
    .valid       (pick_valid)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  logic [CNT_W-1:0] lock_cnt;

  // The current owner keeps the port while it holds lock and req, up to LOCK_MAX grants.
  assign relock = (state == RESP) && |(win_oh & lock & req) &&
                  (lock_cnt < CNT_W'(LOCK_MAX - 1));
`else
  assign relock = 1'b0;
`endif

  assign next_oh    = relock ? win_oh : pick_oh;
  assign next_valid = relock || pick_valid;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_we                = 1'b0;
    sel_addr              = '0;
    sel_wdata             = '0;
    next_oh_ext           = '0;
    next_oh_ext[NREQ-1:0] = next_oh;
    for (int i = 0; i < NREQ; i++) begin
      if (next_oh[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_winner <= IDX_W'(NREQ - 1);
      win_oh      <= '0;
      we_l        <= 1'b0;
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_cnt    <= '0;
`endif
    end else begin
      gnt       <= '0;
      ack       <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ACCESS: begin
          ack   <= win_oh;
          busy  <= 1'b1;
          state <= RESP;
          if (!we_l) rdata <= mem_rdata;
        end
        IDLE, RESP: begin
          if (next_valid) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            win_oh      <= next_oh;
            last_winner <= onehot_idx(next_oh_ext);
            we_l        <= sel_we;
            gnt         <= next_oh;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;
            mem_read    <= !sel_we;
            mem_write   <= sel_we;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef MEM_ARB_LOCK_EN
          lock_cnt <= relock ? lock_cnt + 1'b1 : '0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     we;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [NREQ-1:0]     lock;
`endif
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic [AW-1:0]       mem_addr;
  logic                mem_read;
  logic                mem_write;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef MEM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory behind the port, written only by the DUT's strobes.
  logic [7:0] tb_mem   [64];
  logic [7:0] load_img [64];
  logic [7:0] ref_mem  [64];
  logic       load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= load_img[i];
    end else if (mem_write) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? tb_mem[mem_addr] : 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i, input bit r, input bit w, input logic [5:0] a, input logic [7:0] d);
    req[i]             = r;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    lock  = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int          who;
    bit          wr;
    logic [5:0]  a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Reference model state: pending requester transactions and the port's current job.
  bit         p_req  [NREQ];
  bit         p_we   [NREQ];
  logic [5:0] p_addr [NREQ];
  logic [7:0] p_wd   [NREQ];
  bit         m_access, m_resp, found;
  int         m_win, m_last, idx;
  bit         m_we;
  logic [5:0] m_addr;
  logic [7:0] m_wd;
  logic [7:0] m_rdata;

  logic [1:0] exp_g, exp_a;
  int         grants [$];

  initial begin
    reset   = 1'b0;
    load_en = 1'b0;
    req     = '0;
    we      = '0;
    addr    = '0;
    wdata   = '0;
`ifdef MEM_ARB_LOCK_EN
    lock    = '0;
`endif

    vecs[0] = '{0, 1'b0, 6'h05, 8'h00, 8'hA7};
    vecs[1] = '{1, 1'b1, 6'h3F, 8'h5C, 8'hA7};
    vecs[2] = '{0, 1'b0, 6'h3F, 8'h00, 8'h5C};
    vecs[3] = '{1, 1'b0, 6'h05, 8'h00, 8'hA7};
    vecs[4] = '{0, 1'b1, 6'h05, 8'h3C, 8'hA7};
    vecs[5] = '{1, 1'b0, 6'h05, 8'h00, 8'h3C};
    vecs[6] = '{1, 1'b1, 6'h00, 8'hFF, 8'h3C};
    vecs[7] = '{0, 1'b0, 6'h00, 8'h00, 8'hFF};

    for (int i = 0; i < 64; i++) load_img[i] = 8'($urandom);
    load_img[5] = 8'hA7;
    for (int i = 0; i < 64; i++) ref_mem[i] = load_img[i];
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_ack",       32'(ack),       32'd0);
    check("rst_rdata",     32'(rdata),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mem_read",  32'(mem_read),  32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed single accesses
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].who, 1'b1, vecs[v].wr, vecs[v].a, vecs[v].d);
      exp_g = 2'(1 << vecs[v].who);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", v),       32'(gnt),       32'(exp_g));
      check($sformatf("vec%0d_mem_read", v),  32'(mem_read),  32'(!vecs[v].wr));
      check($sformatf("vec%0d_mem_write", v), 32'(mem_write), 32'(vecs[v].wr));
      check($sformatf("vec%0d_mem_addr", v),  32'(mem_addr),  32'(vecs[v].a));
      if (vecs[v].wr) check($sformatf("vec%0d_mem_wdata", v), 32'(mem_wdata), 32'(vecs[v].d));
      drive(vecs[v].who, 1'b0, 1'b0, 6'h00, 8'h00);
      @(negedge clk);
      check($sformatf("vec%0d_ack", v),     32'(ack),                  32'(exp_g));
      check($sformatf("vec%0d_gnt_off", v), 32'(gnt),                  32'd0);
      check($sformatf("vec%0d_strobes", v), 32'({mem_read, mem_write}), 32'd0);
      check($sformatf("vec%0d_rdata", v),   32'(rdata),                32'(vecs[v].exp_rd));
      if (vecs[v].wr) ref_mem[vecs[v].a] = vecs[v].d;
      @(negedge clk);
      check($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
    end

    // Both requesters held: grants alternate 0,1,0,1 two cycles apart
    do_reset();
    drive(0, 1'b1, 1'b0, 6'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 6'h02, 8'h00);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      exp_g = (t % 2 == 1) ? ((((t - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_a = (t % 2 == 0) ? ((((t - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("alt%0d_gnt", t), 32'(gnt), 32'(exp_g));
      check($sformatf("alt%0d_ack", t), 32'(ack), 32'(exp_a));
      if (exp_a != 2'b00)
        check($sformatf("alt%0d_rdata", t), 32'(rdata), 32'(ref_mem[(exp_a == 2'b01) ? 1 : 2]));
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Reset asserted in the middle of an access
    do_reset();
    drive(0, 1'b1, 1'b0, 6'h05, 8'h00);
    @(negedge clk);
    check("rstmid_read_pre", 32'(mem_read), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_read_drop", 32'(mem_read), 32'd0);
    check("rstmid_gnt_drop",  32'(gnt),      32'd0);
    check("rstmid_busy_drop", 32'(busy),     32'd0);
    drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("rstmid_no_ack1", 32'(ack), 32'd0);
    @(negedge clk);
    check("rstmid_no_ack2", 32'(ack), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 6'h3F, 8'h00);
    @(negedge clk);
    check("rstmid_gnt1", 32'(gnt), 32'b10);
    drive(1, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("rstmid_ack1",   32'(ack),   32'b10);
    check("rstmid_rdata1", 32'(rdata), 32'h5C);
    @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
    // Locked requester 0 gets LOCK_MAX consecutive grants before requester 1
    do_reset();
    lock = 2'b01;
    drive(0, 1'b1, 1'b0, 6'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 6'h3F, 8'h00);
    grants.delete();
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) grants.push_back((gnt == 2'b01) ? 0 : 1);
    end
    begin
      int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      check("lock_grant_count", 32'(grants.size() >= 10), 32'd1);
      for (int i = 0; i < 10; i++)
        if (i < grants.size()) check($sformatf("lock_grant%0d", i), 32'(grants[i]), 32'(exp_seq[i]));
    end
    req  = '0;
    lock = '0;
    repeat (2) @(negedge clk);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    m_access = 1'b0;
    m_resp   = 1'b0;
    m_last   = NREQ - 1;
    m_win    = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wd     = '0;
    m_rdata  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((m_access && m_win == i) || (!p_req[i] && $urandom_range(0, 2) == 0)) begin
          p_req[i]  = (m_access && m_win == i) ? ($urandom_range(0, 1) == 1) : 1'b1;
          p_we[i]   = ($urandom_range(0, 2) == 0);
          p_addr[i] = 6'($urandom_range(0, 15));
          p_wd[i]   = 8'($urandom);
        end
        drive(i, p_req[i], p_we[i], p_addr[i], p_wd[i]);
      end
      @(posedge clk);
      if (m_access) begin
        m_access = 1'b0;
        m_resp   = 1'b1;
        if (m_we) ref_mem[m_addr] = m_wd;
        else      m_rdata = ref_mem[m_addr];
      end else begin
        m_resp = 1'b0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!found && p_req[idx]) begin
            found  = 1'b1;
            m_win  = idx;
            m_we   = p_we[idx];
            m_addr = p_addr[idx];
            m_wd   = p_wd[idx];
          end
        end
        if (found) begin
          m_access = 1'b1;
          m_last   = m_win;
        end
      end
      @(negedge clk);
      exp_g = m_access ? 2'(1 << m_win) : 2'b00;
      exp_a = m_resp   ? 2'(1 << m_win) : 2'b00;
      check($sformatf("rnd%0d_gnt", cyc),       32'(gnt),       32'(exp_g));
      check($sformatf("rnd%0d_ack", cyc),       32'(ack),       32'(exp_a));
      check($sformatf("rnd%0d_busy", cyc),      32'(busy),      32'(m_access || m_resp));
      check($sformatf("rnd%0d_mem_read", cyc),  32'(mem_read),  32'(m_access && !m_we));
      check($sformatf("rnd%0d_mem_write", cyc), 32'(mem_write), 32'(m_access && m_we));
      check($sformatf("rnd%0d_rdata", cyc),     32'(rdata),     32'(m_rdata));
      if (m_access) check($sformatf("rnd%0d_mem_addr", cyc), 32'(mem_addr), 32'(m_addr));
      if (m_access && m_we) check($sformatf("rnd%0d_mem_wdata", cyc), 32'(mem_wdata), 32'(m_wd));
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
